// File: rtl/serial_word_to_bit_stream_msb_first.sv
// Word-to-bitstream serializer: accepts W-bit words over valid/ready and emits
// them MSB first, one bit per clock, with first/last markers and zero-bubble reload.
//
// state | meaning
// IDLE  | no word in flight, ready for a new word, bit outputs low
// SHIFT | emitting sh[W-1]; cnt counts remaining bits after the current one
module serial_word_to_bit_stream_msb_first #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         word_valid,
  input  logic [W-1:0] word,
  output logic         word_ready,
  output logic         bit_valid,
  output logic         new_bit,
  output logic         first_bit,
  output logic         last_bit,
  output logic         busy
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  sh, sh_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sh    <= sh_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sh_nxt     = sh;
    cnt_nxt    = cnt;
    // Ready on the LSB cycle too, so the next word follows without a bubble.
    word_ready = !rst && ((state == IDLE) || (cnt == '0));
    accept     = word_valid && word_ready;
    case (state)
      IDLE: begin
        if (accept) begin
          sh_nxt    = word;
          cnt_nxt   = CNT_MAX;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          sh_nxt  = sh << 1;
          cnt_nxt = cnt - CW'(1);
        end else if (accept) begin
          sh_nxt  = word;
          cnt_nxt = CNT_MAX;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == SHIFT);
    bit_valid = busy;
    new_bit   = busy && sh[W-1];
    first_bit = busy && (cnt == CNT_MAX);
    last_bit  = busy && (cnt == '0);
  end

endmodule

// File: tb/tb_serial_word_to_bit_stream_msb_first.sv
// Bench for the serializer: a W=16 and a W=1 instance checked each cycle against
// a queue-of-bits model of the word stream, with directed and random traffic.
module tb_serial_word_to_bit_stream_msb_first;

  typedef logic [2:0] ent_t; // {bit, first, last}

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v16 = 1'b0, rdy16, bv16, nb16, fb16, lb16, bz16;
  logic [15:0] wd16 = '0;
  logic        v1 = 1'b0, rdy1, bv1, nb1, fb1, lb1, bz1;
  logic [0:0]  wd1 = '0;

  int ncmp = 0;
  int nerr = 0;
  string phase = "init";

  ent_t        q16[$];
  ent_t        q1[$];
  logic [15:0] src16[$];
  logic [0:0]  src1[$];

  always #5 clk = ~clk;

  serial_word_to_bit_stream_msb_first #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .word_valid(v16), .word(wd16), .word_ready(rdy16),
    .bit_valid(bv16), .new_bit(nb16), .first_bit(fb16), .last_bit(lb16), .busy(bz16)
  );

  serial_word_to_bit_stream_msb_first #(.W(1)) dut1 (
    .clk(clk), .rst(rst), .word_valid(v1), .word(wd1), .word_ready(rdy1),
    .bit_valid(bv1), .new_bit(nb1), .first_bit(fb1), .last_bit(lb1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s [%s] observed=%b expected=%b", tag, phase, obs, exp);
    end
  endtask

  task automatic push16(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) q16.push_back({w[i], i == 15, i == 0});
  endtask

  // One clock: drive inputs, compare all outputs to the model, then advance the model.
  task automatic cycle();
    logic r16e, r1e;
    ent_t e16, e1;
    v16  = (src16.size() > 0);
    wd16 = v16 ? src16[0] : 16'($urandom);
    v1   = (src1.size() > 0);
    wd1  = v1 ? src1[0] : 1'($urandom);
    #1;
    e16  = (q16.size() > 0) ? q16[0] : 3'b000;
    e1   = (q1.size() > 0) ? q1[0] : 3'b000;
    r16e = !rst && (q16.size() <= 1);
    r1e  = !rst && (q1.size() <= 1);
    chk("word_ready16", rdy16, r16e);
    chk("bit_valid16", bv16, q16.size() > 0);
    chk("new_bit16", nb16, e16[2]);
    chk("first_bit16", fb16, e16[1]);
    chk("last_bit16", lb16, e16[0]);
    chk("busy16", bz16, q16.size() > 0);
    chk("word_ready1", rdy1, r1e);
    chk("bit_valid1", bv1, q1.size() > 0);
    chk("new_bit1", nb1, e1[2]);
    chk("first_bit1", fb1, e1[1]);
    chk("last_bit1", lb1, e1[0]);
    chk("busy1", bz1, q1.size() > 0);
    @(posedge clk);
    if (rst) begin
      q16.delete();
      q1.delete();
    end else begin
      if (q16.size() > 0) void'(q16.pop_front());
      if (q1.size() > 0) void'(q1.pop_front());
      if (v16 && r16e) push16(src16.pop_front());
      if (v1 && r1e) q1.push_back({src1.pop_front(), 2'b11});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    q16.delete();
    q1.delete();
    chk("async_ready16", rdy16, 1'b0);
    chk("async_bit_valid16", bv16, 1'b0);
    chk("async_new_bit16", nb16, 1'b0);
    chk("async_first16", fb16, 1'b0);
    chk("async_last16", lb16, 1'b0);
    chk("async_busy16", bz16, 1'b0);
    chk("async_ready1", rdy1, 1'b0);
    chk("async_bit_valid1", bv1, 1'b0);
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((src16.size() + q16.size() + src1.size() + q1.size()) > 0 && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_done", (src16.size() + q16.size() + src1.size() + q1.size()) == 0, 1'b1);
  endtask

  initial begin
    phase = "reset";
    @(negedge clk);
    do_reset();
    cycle();

    phase = "single_a5c3";
    src16.push_back(16'hA5C3);
    drain();

    phase = "back_to_back";
    src16.push_back(16'h0005);
    src16.push_back(16'hFFFF);
    src1.push_back(1'b1);
    src1.push_back(1'b0);
    src1.push_back(1'b1);
    drain();

    phase = "gap";
    repeat (3) cycle();
    src16.push_back(16'h3C96);
    drain();

    phase = "reset_mid_word";
    src16.push_back(16'hFFFF);
    repeat (6) cycle();
    do_reset();
    src16.push_back(16'h8000);
    drain();

    phase = "random";
    for (int i = 0; i < 600; i++) begin
      if (src16.size() == 0 && $urandom_range(0, 3) != 0) src16.push_back(16'($urandom));
      if (src1.size() == 0 && $urandom_range(0, 3) != 0) src1.push_back(1'($urandom));
      if (i == 300) do_reset();
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
